// File: rtl/pux_pkg.sv
// Shared definitions for the pux operand path: buffer selects, FSM encoding
// and the default geometry common with pux_si.
package pux_pkg;

    localparam int PUX_DATAW = 16;
    localparam int PUX_WORDS = 8;

    localparam logic [1:0] PUX_SEL_A = 2'd0;
    localparam logic [1:0] PUX_SEL_B = 2'd1;
    localparam logic [1:0] PUX_SEL_M = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } pux_state_e;

endpackage

// File: rtl/pux_opnd_chan.sv
// One operand channel: a WORDS-deep buffer with a host write port, and an
// AXI-Stream source that plays the buffer out in address order on start.
module pux_opnd_chan #(
    parameter int DATAW = 16,
    parameter int WORDS = 8,
    parameter int AW    = 3
) (
    input  logic             axis_clk,
    input  logic             axis_rstn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DATAW-1:0] wr_data,
    input  logic             start,
    input  logic             ready,
    output logic [DATAW-1:0] data,
    output logic             valid,
    output logic             finished,
    output logic             last_xfer
);

    localparam logic [AW-1:0] PTR_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(WORDS - 1);

    logic [DATAW-1:0] mem [WORDS];

    logic [DATAW-1:0] data_q, data_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;   // data_q currently holds word WORDS-1
    logic             fin_q, fin_d;
    logic             xfer;

    // Host write port; the buffer contents survive reset.
    // NOTE: storage arrays carry no reset -- clearing them would cost a mux per
    // bit and the host always loads them before use.
    always_ff @(posedge axis_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next-state for the stream source; pointer saturates at the last word so
    // it never wraps, and last_q marks that the final word is being offered.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        data_d    = data_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        last_d    = last_q;
        fin_d     = fin_q;
        xfer      = valid_q && ready;
        last_xfer = xfer && last_q;
        if (start) begin
            data_d  = mem[PTR_ZERO];
            ptr_d   = PTR_ONE;
            last_d  = 1'b0;
            valid_d = 1'b1;
            fin_d   = 1'b0;
        end else if (xfer) begin
            if (last_q) begin
                valid_d = 1'b0;
                fin_d   = 1'b1;
            end else begin
                data_d = mem[ptr_q];
                last_d = (ptr_q == PTR_LAST);
                if (ptr_q != PTR_LAST) begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
        end
    end

    // Stream source registers.
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            data_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            fin_q   <= fin_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign finished = fin_q;

endmodule

// File: rtl/pux_opnd_streamer.sv
// Operand source upstream of pux_si: three buffers (A, B, M) loaded by the
// host and streamed on request over three independent AXI-Stream channels.
module pux_opnd_streamer
    import pux_pkg::*;
#(
    parameter int DATAW = PUX_DATAW,
    parameter int WORDS = PUX_WORDS,
    parameter int AW    = 3
) (
    input  logic             axis_clk,
    input  logic             axis_rstn,
    input  logic             ld_we,
    input  logic [1:0]       ld_sel,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DATAW-1:0] ld_data,
    output logic             ld_ready,
    input  logic             stream_reqest,
    output logic [DATAW-1:0] axis_abuff_data,
    output logic             axis_abuff_valid,
    input  logic             axis_abuff_ready,
    output logic [DATAW-1:0] axis_bbuff_data,
    output logic             axis_bbuff_valid,
    input  logic             axis_bbuff_ready,
    output logic [DATAW-1:0] axis_mbuff_data,
    output logic             axis_mbuff_valid,
    input  logic             axis_mbuff_ready,
    output logic             busy,
    output logic             done,
    output logic             req_drop
);

    pux_state_e state_q, state_d;
    logic       drop_q, drop_d;
    logic       start;
    logic [2:0] chan_we, chan_fin, chan_last;
    logic       all_fin;

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign ld_ready = !busy;
    assign req_drop = drop_q;
    assign start    = (state_q == ST_IDLE) && stream_reqest;

    // Load-select decode; selector 3 and writes while busy hit nothing.
    always_comb begin
        chan_we    = 3'b000;
        chan_we[0] = ld_we && ld_ready && (ld_sel == PUX_SEL_A);
        chan_we[1] = ld_we && ld_ready && (ld_sel == PUX_SEL_B);
        chan_we[2] = ld_we && ld_ready && (ld_sel == PUX_SEL_M);
    end

    // Sequencer: leave STREAM on the edge where the last open channel
    // completes its final transfer, then hold DONE for one cycle.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q | (stream_reqest && busy);
        all_fin = &(chan_fin | chan_last);
        case (state_q)
            ST_IDLE:   if (stream_reqest) state_d = ST_STREAM;
            ST_STREAM: if (all_fin)       state_d = ST_DONE;
            ST_DONE:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and sticky drop flag.
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    pux_opnd_chan #(.DATAW(DATAW), .WORDS(WORDS), .AW(AW)) u_chan_a (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .wr_en     (chan_we[0]),
        .wr_addr   (ld_addr),
        .wr_data   (ld_data),
        .start     (start),
        .ready     (axis_abuff_ready),
        .data      (axis_abuff_data),
        .valid     (axis_abuff_valid),
        .finished  (chan_fin[0]),
        .last_xfer (chan_last[0])
    );

    pux_opnd_chan #(.DATAW(DATAW), .WORDS(WORDS), .AW(AW)) u_chan_b (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .wr_en     (chan_we[1]),
        .wr_addr   (ld_addr),
        .wr_data   (ld_data),
        .start     (start),
        .ready     (axis_bbuff_ready),
        .data      (axis_bbuff_data),
        .valid     (axis_bbuff_valid),
        .finished  (chan_fin[1]),
        .last_xfer (chan_last[1])
    );

    pux_opnd_chan #(.DATAW(DATAW), .WORDS(WORDS), .AW(AW)) u_chan_m (
        .axis_clk  (axis_clk),
        .axis_rstn (axis_rstn),
        .wr_en     (chan_we[2]),
        .wr_addr   (ld_addr),
        .wr_data   (ld_data),
        .start     (start),
        .ready     (axis_mbuff_ready),
        .data      (axis_mbuff_data),
        .valid     (axis_mbuff_valid),
        .finished  (chan_fin[2]),
        .last_xfer (chan_last[2])
    );

endmodule

// File: tb/tb_pux_opnd_streamer.sv
// Self-checking bench for pux_opnd_streamer: table of stream scenarios with
// per-channel ready patterns, a scoreboard of expected words per channel, and
// hand-written sequences for reset mid-stream and the ignored selector.
module tb_pux_opnd_streamer;

    localparam int DATAW = 16;
    localparam int WORDS = 8;
    localparam int AW    = 3;

    typedef enum int {R_ONE, R_TOG, R_STALL5} rdy_mode_e;

    typedef struct {
        rdy_mode_e ra;
        rdy_mode_e rb;
        rdy_mode_e rm;
        bit        overlap;     // inject a request and an A[0] write mid-stream
        int        exp_done_c;  // cycle (1 = first valid cycle) in which done is seen
    } row_t;

    logic             axis_clk = 1'b0;
    logic             axis_rstn;
    logic             ld_we;
    logic [1:0]       ld_sel;
    logic [AW-1:0]    ld_addr;
    logic [DATAW-1:0] ld_data;
    logic             ld_ready;
    logic             stream_reqest;
    logic [DATAW-1:0] a_data, b_data, m_data;
    logic             a_valid, b_valid, m_valid;
    logic             rdy [3];
    logic             busy, done, req_drop;

    logic [DATAW-1:0] o_data [3];
    logic             o_valid [3];

    logic [DATAW-1:0] model [3][WORDS];
    logic [DATAW-1:0] sb [3][$];
    logic             exp_drop;

    int n_cmp = 0;
    int n_err = 0;

    always #5 axis_clk = ~axis_clk;

    assign o_data[0]  = a_data;
    assign o_data[1]  = b_data;
    assign o_data[2]  = m_data;
    assign o_valid[0] = a_valid;
    assign o_valid[1] = b_valid;
    assign o_valid[2] = m_valid;

    pux_opnd_streamer #(.DATAW(DATAW), .WORDS(WORDS), .AW(AW)) dut (
        .axis_clk         (axis_clk),
        .axis_rstn        (axis_rstn),
        .ld_we            (ld_we),
        .ld_sel           (ld_sel),
        .ld_addr          (ld_addr),
        .ld_data          (ld_data),
        .ld_ready         (ld_ready),
        .stream_reqest    (stream_reqest),
        .axis_abuff_data  (a_data),
        .axis_abuff_valid (a_valid),
        .axis_abuff_ready (rdy[0]),
        .axis_bbuff_data  (b_data),
        .axis_bbuff_valid (b_valid),
        .axis_bbuff_ready (rdy[1]),
        .axis_mbuff_data  (m_data),
        .axis_mbuff_valid (m_valid),
        .axis_mbuff_ready (rdy[2]),
        .busy             (busy),
        .done             (done),
        .req_drop         (req_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ready_of(input rdy_mode_e m, input int c);
        case (m)
            R_ONE:    return 1'b1;
            R_TOG:    return (c % 2) == 1;
            R_STALL5: return c > 5;
            default:  return 1'b1;
        endcase
    endfunction

    // Called at a negedge, returns at a negedge.
    task automatic load(input logic [1:0] sel, input int addr, input logic [DATAW-1:0] d);
        ld_we   = 1'b1;
        ld_sel  = sel;
        ld_addr = AW'(addr);
        ld_data = d;
        @(negedge axis_clk);
        ld_we = 1'b0;
        if (sel != 2'd3) model[sel][addr] = d;
    endtask

    task automatic push_stream();
        for (int ch = 0; ch < 3; ch++)
            for (int i = 0; i < WORDS; i++)
                sb[ch].push_back(model[ch][i]);
    endtask

    // Request a stream at the current negedge and play it out under the
    // row's ready pattern; returns at the negedge one cycle after done.
    task automatic run_stream(input row_t r, input int idx);
        bit seen = 1'b0;
        push_stream();
        stream_reqest = 1'b1;
        @(negedge axis_clk);
        stream_reqest = 1'b0;
        for (int ch = 0; ch < 3; ch++)
            check($sformatf("row%0d_req_to_valid_ch%0d", idx, ch), 32'(o_valid[ch]), 32'd1);
        for (int c = 1; c <= 60; c++) begin
            rdy[0] = ready_of(r.ra, c);
            rdy[1] = ready_of(r.rb, c);
            rdy[2] = ready_of(r.rm, c);
            if (r.overlap && c == 2) begin
                stream_reqest = 1'b1;
                ld_we   = 1'b1;
                ld_sel  = 2'd0;
                ld_addr = '0;
                ld_data = 16'hDEAD;
                check($sformatf("row%0d_ld_ready_busy", idx), 32'(ld_ready), 32'd0);
            end
            if (r.overlap && c == 3) begin
                stream_reqest = 1'b0;
                ld_we    = 1'b0;
                exp_drop = 1'b1;
                check($sformatf("row%0d_req_drop_set", idx), 32'(req_drop), 32'd1);
            end
            if (done) begin
                seen = 1'b1;
                check($sformatf("row%0d_done_cycle", idx), 32'(c), 32'(r.exp_done_c));
                for (int ch = 0; ch < 3; ch++) begin
                    check($sformatf("row%0d_valid_low_at_done_ch%0d", idx, ch), 32'(o_valid[ch]), 32'd0);
                    check($sformatf("row%0d_words_left_ch%0d", idx, ch), 32'(sb[ch].size()), 32'd0);
                end
                break;
            end
            check($sformatf("row%0d_busy_c%0d", idx, c), 32'(busy), 32'd1);
            for (int ch = 0; ch < 3; ch++) begin
                if (o_valid[ch]) begin
                    if (sb[ch].size() == 0) begin
                        check($sformatf("row%0d_extra_word_ch%0d", idx, ch), 32'd1, 32'd0);
                    end else begin
                        check($sformatf("row%0d_data_ch%0d_c%0d", idx, ch, c), 32'(o_data[ch]), 32'(sb[ch][0]));
                        if (rdy[ch]) void'(sb[ch].pop_front());
                    end
                end
            end
            @(negedge axis_clk);
        end
        if (!seen) check($sformatf("row%0d_done_timeout", idx), 32'd0, 32'd1);
        @(negedge axis_clk);
        check($sformatf("row%0d_done_one_cycle", idx), 32'(done), 32'd0);
        check($sformatf("row%0d_busy_after", idx), 32'(busy), 32'd0);
        check($sformatf("row%0d_no_restart", idx), 32'(a_valid | b_valid | m_valid), 32'd0);
        check($sformatf("row%0d_req_drop", idx), 32'(req_drop), 32'(exp_drop));
        for (int ch = 0; ch < 3; ch++) sb[ch].delete();
    endtask

    row_t tbl [5];

    initial begin
        tbl[0] = '{ra: R_ONE,    rb: R_ONE,    rm: R_ONE,    overlap: 1'b0, exp_done_c: 9};
        tbl[1] = '{ra: R_TOG,    rb: R_STALL5, rm: R_ONE,    overlap: 1'b1, exp_done_c: 16};
        tbl[2] = '{ra: R_STALL5, rb: R_ONE,    rm: R_TOG,    overlap: 1'b0, exp_done_c: 16};
        tbl[3] = '{ra: R_ONE,    rb: R_ONE,    rm: R_STALL5, overlap: 1'b0, exp_done_c: 14};
        tbl[4] = '{ra: R_ONE,    rb: R_ONE,    rm: R_ONE,    overlap: 1'b0, exp_done_c: 9};

        axis_rstn     = 1'b0;
        ld_we         = 1'b0;
        ld_sel        = '0;
        ld_addr       = '0;
        ld_data       = '0;
        stream_reqest = 1'b0;
        exp_drop      = 1'b0;
        for (int ch = 0; ch < 3; ch++) rdy[ch] = 1'b0;

        repeat (2) @(negedge axis_clk);
        check("rst_valid_a", 32'(a_valid), 32'd0);
        check("rst_valid_b", 32'(b_valid), 32'd0);
        check("rst_valid_m", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req_drop", 32'(req_drop), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_data_a", 32'(a_data), 32'd0);
        axis_rstn = 1'b1;
        @(negedge axis_clk);

        for (int i = 0; i < WORDS; i++) begin
            load(2'd0, i, 16'h1000 + 16'(i));
            load(2'd1, i, 16'h2000 + 16'(i));
            load(2'd2, i, 16'h3000 + 16'(i));
        end

        // Back-to-back rows: each next request lands one cycle after done.
        for (int r = 0; r < 4; r++) run_stream(tbl[r], r);

        // Reset after three A transfers at full throughput.
        push_stream();
        stream_reqest = 1'b1;
        @(negedge axis_clk);
        stream_reqest = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            for (int ch = 0; ch < 3; ch++) rdy[ch] = 1'b1;
            check($sformatf("rstmid_data_a_c%0d", c), 32'(a_data), 32'(sb[0][0]));
            for (int ch = 0; ch < 3; ch++) void'(sb[ch].pop_front());
            @(negedge axis_clk);
        end
        axis_rstn = 1'b0;
        #1;
        check("rstmid_valid_a", 32'(a_valid), 32'd0);
        check("rstmid_valid_b", 32'(b_valid), 32'd0);
        check("rstmid_valid_m", 32'(m_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_req_drop", 32'(req_drop), 32'd0);
        exp_drop = 1'b0;
        for (int ch = 0; ch < 3; ch++) sb[ch].delete();
        @(negedge axis_clk);
        axis_rstn = 1'b1;
        @(negedge axis_clk);
        run_stream(tbl[0], 10);

        // Ignored selector, then a fresh random B image.
        load(2'd3, 0, 16'hBEEF);
        load(2'd3, WORDS - 1, 16'hBEEF);
        for (int i = 0; i < WORDS; i++) load(2'd1, i, 16'($urandom));
        run_stream(tbl[4], 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
